// File: rtl/pattern_scan_ctrl_if.sv
// pattern_scan_ctrl_if
//   Bundles the configuration, word-input handshake and status signals of pattern_scan_ctrl.
//   master: the word source / configurator (drives cfg_* and in_*, observes status).
//   slave : the pattern_scan_ctrl block itself.
// Signals
//   cfg_we, cfg_pattern[PAT_MAX], cfg_len[$clog2(PAT_MAX+1)], cfg_overlap   configuration write
//   in_valid, in_data[WORD_W], in_last, in_ready                            word handshake
//   match_pulse, match_count[CNT_W], overflow, busy, done                  status
interface pattern_scan_ctrl_if #(
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned CNT_W   = 8
);
    localparam int unsigned LEN_W = $clog2(PAT_MAX + 1);

    logic               cfg_we;
    logic [PAT_MAX-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;

    logic               in_valid;
    logic [WORD_W-1:0]  in_data;
    logic               in_last;
    logic               in_ready;

    logic               match_pulse;
    logic [CNT_W-1:0]   match_count;
    logic               overflow;
    logic               busy;
    logic               done;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap,
        output in_valid, in_data, in_last,
        input  in_ready,
        input  match_pulse, match_count, overflow, busy, done
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap,
        input  in_valid, in_data, in_last,
        output in_ready,
        output match_pulse, match_count, overflow, busy, done
    );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//   Accepts parallel words over a valid/ready handshake and shifts them MSB-first through a
//   programmable serial pattern detector. Counts matches per frame (saturating, with sticky
//   overflow) and pulses done at the end of a frame (word flagged in_last).
// Ports
//   clk  rising-edge clock
//   rst  synchronous, active-low reset
//   bus  pattern_scan_ctrl_if.slave: cfg_* config write, in_* word handshake, status outputs
module pattern_scan_ctrl #(
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pattern_scan_ctrl_if.slave    bus
);
    localparam int unsigned LEN_W = $clog2(PAT_MAX + 1);
    localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
    localparam logic [LEN_W-1:0]   FILL_MAX    = LEN_W'(PAT_MAX);
    localparam logic [BIT_W-1:0]   LAST_BIT    = BIT_W'(WORD_W - 1);
    localparam logic [PAT_MAX-1:0] DEF_PATTERN = PAT_MAX'(4'b1011);
    localparam logic [LEN_W-1:0]   DEF_LEN     = LEN_W'(4);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               last_q, last_d;
    logic [PAT_MAX-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               pulse_q, pulse_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic [PAT_MAX-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;

    logic               accept;
    logic [PAT_MAX-1:0] len_mask;
    logic [PAT_MAX-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic               hit;

    assign bus.in_ready    = rst && (state_q == StIdle);
    assign accept          = bus.in_valid && bus.in_ready;
    assign bus.match_pulse = pulse_q;
    assign bus.match_count = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.busy        = busy_q;
    assign bus.done        = (state_q == StDone);

    // Match check sees the history with the bit being shifted this cycle already included.
    always_comb begin
        for (int i = 0; i < int'(PAT_MAX); i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        hist_shift = (hist_q << 1) | PAT_MAX'(word_q[WORD_W-1]);
        fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        hit        = (fill_inc >= len_q) && ((hist_shift & len_mask) == (pat_q & len_mask));
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        pulse_d   = 1'b0;
        count_d   = count_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    word_d    = bus.in_data;
                    last_d    = bus.in_last;
                    bit_cnt_d = '0;
                    state_d   = StShift;
                    if (!busy_q) begin
                        count_d = '0;
                        ovf_d   = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end
            StShift: begin
                word_d    = word_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                hist_d    = hist_shift;
                fill_d    = fill_inc;
                if (hit) begin
                    pulse_d = 1'b1;
                    // Non-overlapping mode: forget the consumed bits.
                    if (!ovl_q) begin
                        fill_d = '0;
                    end
                    if (count_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    if (last_q) begin
                        state_d = StDone;
                        hist_d  = '0;
                        fill_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        // Configuration is only writable between frames.
        if (bus.cfg_we && (state_q == StIdle) && !busy_q) begin
            pat_d = bus.cfg_pattern;
            ovl_d = bus.cfg_overlap;
            if (bus.cfg_len == '0) begin
                len_d = LEN_W'(1);
            end else if (bus.cfg_len > FILL_MAX) begin
                len_d = FILL_MAX;
            end else begin
                len_d = bus.cfg_len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            word_q    <= '0;
            bit_cnt_q <= '0;
            last_q    <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            pulse_q   <= 1'b0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            pat_q     <= DEF_PATTERN;
            len_q     <= DEF_LEN;
            ovl_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            bit_cnt_q <= bit_cnt_d;
            last_q    <= last_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pulse_q   <= pulse_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
        end
    end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl
//   Directed bench for pattern_scan_ctrl. Two instances share all stimulus: bus_a with an 8-bit
//   match counter and bus_b with a 2-bit counter for saturation/overflow behaviour.
//   Pulse masks: bit k-1 set means match_pulse was seen for shift bit k of the word.
module tb_pattern_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    pattern_scan_ctrl_if #(.WORD_W(8), .PAT_MAX(8), .CNT_W(8)) bus_a ();
    pattern_scan_ctrl_if #(.WORD_W(8), .PAT_MAX(8), .CNT_W(2)) bus_b ();

    pattern_scan_ctrl #(.WORD_W(8), .PAT_MAX(8), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    pattern_scan_ctrl #(.WORD_W(8), .PAT_MAX(8), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [7:0] d, input logic l);
        bus_a.in_valid = v; bus_a.in_data = d; bus_a.in_last = l;
        bus_b.in_valid = v; bus_b.in_data = d; bus_b.in_last = l;
    endtask

    task automatic set_cfg(input logic we, input logic [7:0] p, input logic [3:0] n,
                           input logic o);
        bus_a.cfg_we = we; bus_a.cfg_pattern = p; bus_a.cfg_len = n; bus_a.cfg_overlap = o;
        bus_b.cfg_we = we; bus_b.cfg_pattern = p; bus_b.cfg_len = n; bus_b.cfg_overlap = o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for an idle, non-busy block and writes the configuration.
    task automatic cfg_write(input logic [7:0] p, input logic [3:0] n, input logic o);
        int waited = 0;
        while (!(bus_a.in_ready && !bus_a.busy) && waited < 20) begin
            tick();
            waited++;
        end
        if (!(bus_a.in_ready && !bus_a.busy)) begin
            check_eq("cfg_idle_timeout", bus_a.in_ready, 1);
            return;
        end
        set_cfg(1'b1, p, n, o);
        tick();
        set_cfg(1'b0, 8'h00, 4'd0, 1'b0);
    endtask

    // Sends one word and watches its 8 shift cycles. cfg_at>0 fires an ignored config write
    // (pattern 101, len 3, overlap 1) during shift cycle cfg_at.
    task automatic send_word(input logic [7:0] data, input logic last, input int cfg_at,
                             output logic [7:0] mask, output logic done_seen,
                             output logic busy_seen);
        int waited = 0;
        mask = '0;
        done_seen = 1'b0;
        busy_seen = 1'b0;
        set_in(1'b1, data, last);
        while (!bus_a.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!bus_a.in_ready) begin
            check_eq("ready_timeout", bus_a.in_ready, 1);
            set_in(1'b0, 8'h00, 1'b0);
            return;
        end
        tick();
        set_in(1'b0, 8'h00, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            if (k == cfg_at) set_cfg(1'b1, 8'b101, 4'd3, 1'b1);
            tick();
            if (k == cfg_at) set_cfg(1'b0, 8'h00, 4'd0, 1'b0);
            mask[k-1] = bus_a.match_pulse;
            if (k == 1) busy_seen = bus_a.busy;
        end
        done_seen = bus_a.done;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m;
        logic       dn;
        logic       bz;

        set_in(1'b0, 8'h00, 1'b0);
        set_cfg(1'b0, 8'h00, 4'd0, 1'b0);

        // Reset state
        tick(); tick(); tick();
        check_eq("rst_in_ready", bus_a.in_ready, 0);
        check_eq("rst_busy", bus_a.busy, 0);
        check_eq("rst_count", bus_a.match_count, 0);
        check_eq("rst_overflow", bus_a.overflow, 0);
        check_eq("rst_done", bus_a.done, 0);
        check_eq("rst_pulse", bus_a.match_pulse, 0);
        rst = 1'b1;
        tick();
        check_eq("idle_in_ready", bus_a.in_ready, 1);

        // Default config, two non-overlapping matches at bits 4 and 8
        send_word(8'hBB, 1'b1, 0, m, dn, bz);
        check_eq("bb_mask", m, 8'h88);
        check_eq("bb_done", dn, 1);
        check_eq("bb_busy", bz, 1);
        check_eq("bb_count", bus_a.match_count, 2);
        tick();
        check_eq("bb_done_1cyc", bus_a.done, 0);
        check_eq("bb_busy_after", bus_a.busy, 0);
        check_eq("bb_count_hold", bus_a.match_count, 2);

        // Config write during SHIFT is ignored
        send_word(8'hB0, 1'b1, 2, m, dn, bz);
        check_eq("cfg_shift_mask", m, 8'h08);
        check_eq("cfg_shift_count", bus_a.match_count, 1);
        send_word(8'h50, 1'b1, 0, m, dn, bz);
        check_eq("cfg_kept_mask", m, 8'h00);

        // Overlap off vs on
        send_word(8'hB6, 1'b1, 0, m, dn, bz);
        check_eq("novl_mask", m, 8'h08);
        check_eq("novl_count", bus_a.match_count, 1);
        cfg_write(8'b1011, 4'd4, 1'b1);
        send_word(8'hB6, 1'b1, 0, m, dn, bz);
        check_eq("ovl_mask", m, 8'h48);
        check_eq("ovl_count", bus_a.match_count, 2);

        // Cross-word match on overall bit 9
        cfg_write(8'b1011, 4'd4, 1'b0);
        send_word(8'h05, 1'b0, 0, m, dn, bz);
        check_eq("xw0_mask", m, 8'h00);
        check_eq("xw0_done", dn, 0);
        send_word(8'h80, 1'b1, 0, m, dn, bz);
        check_eq("xw1_mask", m, 8'h01);
        check_eq("xw_count", bus_a.match_count, 1);

        // History cleared between frames
        send_word(8'h05, 1'b1, 0, m, dn, bz);
        send_word(8'h80, 1'b1, 0, m, dn, bz);
        check_eq("newframe_mask", m, 8'h00);
        check_eq("newframe_count", bus_a.match_count, 0);

        // Saturation: 5 matches in one frame
        send_word(8'hBB, 1'b0, 0, m, dn, bz);
        check_eq("sat0_mask", m, 8'h88);
        send_word(8'hBB, 1'b0, 0, m, dn, bz);
        check_eq("sat1_mask", m, 8'h88);
        send_word(8'hB0, 1'b1, 0, m, dn, bz);
        check_eq("sat2_mask", m, 8'h08);
        check_eq("sat_count_b", bus_b.match_count, 3);
        check_eq("sat_ovf_b", bus_b.overflow, 1);
        check_eq("sat_count_a", bus_a.match_count, 5);
        check_eq("sat_ovf_a", bus_a.overflow, 0);
        send_word(8'h00, 1'b1, 0, m, dn, bz);
        check_eq("clr_count_b", bus_b.match_count, 0);
        check_eq("clr_ovf_b", bus_b.overflow, 0);

        // Length clamping: 0 -> 1, 15 -> 8
        cfg_write(8'h01, 4'd0, 1'b1);
        send_word(8'hA0, 1'b1, 0, m, dn, bz);
        check_eq("len0_mask", m, 8'h05);
        cfg_write(8'hA5, 4'd15, 1'b0);
        send_word(8'hA5, 1'b1, 0, m, dn, bz);
        check_eq("len15_mask", m, 8'h80);

        // Reset during shift cycle 3 with a config that would match on bit 3
        cfg_write(8'b101, 4'd3, 1'b1);
        set_in(1'b1, 8'hBB, 1'b1);
        begin
            int waited = 0;
            while (!bus_a.in_ready && waited < 20) begin
                tick();
                waited++;
            end
        end
        check_eq("abort_ready", bus_a.in_ready, 1);
        tick();
        set_in(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_eq("abort_in_ready", bus_a.in_ready, 0);
        check_eq("abort_busy", bus_a.busy, 0);
        check_eq("abort_count", bus_a.match_count, 0);
        check_eq("abort_pulse", bus_a.match_pulse, 0);
        check_eq("abort_done", bus_a.done, 0);
        rst = 1'b1;
        tick();
        check_eq("abort_idle", bus_a.in_ready, 1);
        check_eq("abort_no_done", bus_a.done, 0);
        send_word(8'hBB, 1'b1, 0, m, dn, bz);
        check_eq("abort_defcfg_mask", m, 8'h88);
        check_eq("abort_defcfg_count", bus_a.match_count, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
